// File: rtl/fifo_drain_ctrl_if.sv
// rtl/fifo_drain_ctrl_if.sv - FIFO read port and transmit stream bundle for fifo_drain_ctrl
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  enable;
  logic                  flush;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ADDR_WIDTH-1:0] fifo_usedw;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_rdreq;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;
  logic [15:0]           tx_count;

  modport master (
    input  enable, flush, fifo_empty, fifo_full, fifo_usedw, fifo_q, m_ready,
    output fifo_rdreq, m_data, m_valid, busy, tx_count
  );

  modport slave (
    output enable, flush, fifo_empty, fifo_full, fifo_usedw, fifo_q, m_ready,
    input  fifo_rdreq, m_data, m_valid, busy, tx_count
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - read-side drain scheduler for the USB-to-UART byte FIFO
// Starts a burst on watermark, idle timeout or flush and drains one word in flight at a time.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int THRESHOLD   = 16,
  parameter int TIMEOUT     = 1000,
  parameter int TIMER_WIDTH = 16
) (
  input logic              clock,
  input logic              aclr,
  fifo_drain_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]    LVL_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]    LVL_THR   = (ADDR_WIDTH+1)'(THRESHOLD);
  localparam logic [TIMER_WIDTH-1:0] TMO       = TIMER_WIDTH'(TIMEOUT);

  state_t                 state_q, state_d;
  logic                   fifo_rdreq_q, fifo_rdreq_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic                   busy_q, busy_d;
  logic [15:0]            tx_count_q, tx_count_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   flush_pending_q, flush_pending_d;

  logic [ADDR_WIDTH:0]    level;
  logic                   expired;
  logic                   trigger;
  logic                   burst_end_clear;

  always_comb begin
    // usedw wraps to 0 when full, so the full flag supplies the missing top value
    level   = bus.fifo_full ? LVL_DEPTH : {1'b0, bus.fifo_usedw};
    expired = (timer_q == TMO);
    trigger = bus.enable && !bus.fifo_empty &&
              ((level >= LVL_THR) || expired || flush_pending_q);

    state_d         = state_q;
    fifo_rdreq_d    = 1'b0;
    m_valid_d       = m_valid_q;
    m_data_d        = m_data_q;
    tx_count_d      = tx_count_q;
    burst_end_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d      = REQ;
          fifo_rdreq_d = 1'b1;
        end
      end
      REQ: begin
        state_d = LOAD;
      end
      LOAD: begin
        m_data_d  = bus.fifo_q;
        m_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (bus.m_ready) begin
          m_valid_d       = 1'b0;
          tx_count_d      = tx_count_q + 16'd1;
          burst_end_clear = bus.fifo_empty;
          if (!bus.fifo_empty && bus.enable) begin
            state_d      = REQ;
            fifo_rdreq_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE || bus.fifo_empty) begin
      timer_d = '0;
    end else if (!expired) begin
      timer_d = timer_q + TIMER_WIDTH'(1);
    end else begin
      timer_d = timer_q;
    end

    // a new flush request outranks any clear landing in the same cycle
    if (bus.flush) begin
      flush_pending_d = 1'b1;
    end else if (burst_end_clear || (state_q == IDLE && bus.fifo_empty)) begin
      flush_pending_d = 1'b0;
    end else begin
      flush_pending_d = flush_pending_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q         <= IDLE;
      fifo_rdreq_q    <= 1'b0;
      m_valid_q       <= 1'b0;
      m_data_q        <= '0;
      busy_q          <= 1'b0;
      tx_count_q      <= '0;
      timer_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fifo_rdreq_q    <= fifo_rdreq_d;
      m_valid_q       <= m_valid_d;
      m_data_q        <= m_data_d;
      busy_q          <= busy_d;
      tx_count_q      <= tx_count_d;
      timer_q         <= timer_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign bus.fifo_rdreq = fifo_rdreq_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.busy       = busy_q;
  assign bus.tx_count   = tx_count_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - self-checking bench for fifo_drain_ctrl
// Two instances: A (depth 16, threshold 4, timeout 200) and B (depth 4, threshold 4, timeout 10).
module tb_fifo_drain_ctrl;

  logic clock = 1'b0;
  logic aclr  = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  fifo_drain_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) a_if ();
  fifo_drain_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) b_if ();

  fifo_drain_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .THRESHOLD(4), .TIMEOUT(200), .TIMER_WIDTH(16))
    dut_a (.clock(clock), .aclr(aclr), .bus(a_if.master));
  fifo_drain_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .THRESHOLD(4), .TIMEOUT(10), .TIMER_WIDTH(16))
    dut_b (.clock(clock), .aclr(aclr), .bus(b_if.master));

  // behavioural FIFOs with registered read data
  logic [7:0] mem_a [0:15];
  logic [3:0] wp_a = '0, rp_a = '0;
  logic [4:0] cnt_a = '0;
  logic [7:0] q_a = '0, wd_a = '0;
  logic       wr_a = 1'b0;
  logic [7:0] mem_b [0:3];
  logic [1:0] wp_b = '0, rp_b = '0;
  logic [2:0] cnt_b = '0;
  logic [7:0] q_b = '0, wd_b = '0;
  logic       wr_b = 1'b0;

  always @(posedge clock) begin
    if (a_if.fifo_rdreq && cnt_a != 0) begin q_a <= mem_a[rp_a]; rp_a <= rp_a + 4'd1; end
    if (wr_a) begin mem_a[wp_a] <= wd_a; wp_a <= wp_a + 4'd1; end
    cnt_a <= cnt_a + 5'(wr_a) - 5'(a_if.fifo_rdreq && cnt_a != 0);
    if (b_if.fifo_rdreq && cnt_b != 0) begin q_b <= mem_b[rp_b]; rp_b <= rp_b + 2'd1; end
    if (wr_b) begin mem_b[wp_b] <= wd_b; wp_b <= wp_b + 2'd1; end
    cnt_b <= cnt_b + 3'(wr_b) - 3'(b_if.fifo_rdreq && cnt_b != 0);
  end

  assign a_if.fifo_empty = (cnt_a == 0);
  assign a_if.fifo_full  = (cnt_a == 16);
  assign a_if.fifo_usedw = cnt_a[3:0];
  assign a_if.fifo_q     = q_a;
  assign b_if.fifo_empty = (cnt_b == 0);
  assign b_if.fifo_full  = (cnt_b == 4);
  assign b_if.fifo_usedw = cnt_b[1:0];
  assign b_if.fifo_q     = q_b;

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int hs_cyc_a [$];
  int hs_a = 0, hs_b = 0, rd_a = 0, rd_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic write_a(input logic [7:0] d);
    wr_a = 1'b1; wd_a = d; exp_a.push_back(d);
    step;
    wr_a = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    wr_b = 1'b1; wd_b = d; exp_b.push_back(d);
    step;
    wr_b = 1'b0;
  endtask

  // scoreboard: every accepted word must be the oldest word written
  always @(negedge clock) begin
    if (!aclr) begin
      if (a_if.m_valid && a_if.m_ready) begin
        if (exp_a.size() == 0) check("a_extra_word", exp_a.size(), 1);
        else check("a_data", a_if.m_data, exp_a.pop_front());
        hs_a++;
        hs_cyc_a.push_back(cyc);
      end
      if (b_if.m_valid && b_if.m_ready) begin
        if (exp_b.size() == 0) check("b_extra_word", exp_b.size(), 1);
        else check("b_data", b_if.m_data, exp_b.pop_front());
        hs_b++;
      end
      if (a_if.fifo_rdreq) begin rd_a++; check("a_rdreq_safe", {a_if.fifo_empty, a_if.m_valid}, 0); end
      if (b_if.fifo_rdreq) begin rd_b++; check("b_rdreq_safe", {b_if.fifo_empty, b_if.m_valid}, 0); end
    end
  end

  initial begin
    int base, rbase, n, hs_rst, k, unstable;
    logic [7:0] held;

    a_if.enable = 1'b1; a_if.flush = 1'b0; a_if.m_ready = 1'b0;
    b_if.enable = 1'b1; b_if.flush = 1'b0; b_if.m_ready = 1'b0;
    repeat (3) step;
    check("rst_m_valid", a_if.m_valid, 0);
    check("rst_rdreq", a_if.fifo_rdreq, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_tx_count", a_if.tx_count, 0);
    check("rst_m_data", a_if.m_data, 0);
    aclr = 1'b0;
    step;

    // watermark on A
    a_if.m_ready = 1'b1;
    write_a(8'h11); write_a(8'h22); write_a(8'h33);
    rbase = rd_a;
    repeat (50) step;
    check("wm_no_read_below", rd_a - rbase, 0);
    base = hs_cyc_a.size();
    write_a(8'h44);
    k = 0;
    while (hs_a < 4 && k < 60) begin step; k++; end
    check("wm_handshakes", hs_a, 4);
    check("wm_busy_falls", a_if.busy, 0);
    check("wm_tx_count", a_if.tx_count, 4);
    for (int i = base + 1; i < hs_cyc_a.size(); i++)
      check("wm_spacing", hs_cyc_a[i] - hs_cyc_a[i-1], 3);

    // timeout on B: count cycles from the first non-empty cycle to fifo_rdreq
    b_if.m_ready = 1'b1;
    write_b(8'hA5);
    n = 0;
    while (!b_if.fifo_rdreq && n < 40) begin step; n++; end
    check("to_rdreq_delay", n, 11);
    step; step;
    check("to_m_valid", b_if.m_valid, 1);
    check("to_m_data", b_if.m_data, 8'hA5);
    repeat (3) step;

    // flush with backpressure on B
    b_if.m_ready = 1'b0;
    write_b(8'h5A); write_b(8'hC3);
    b_if.flush = 1'b1; step; b_if.flush = 1'b0;
    rbase = rd_b; unstable = 0; held = 8'h00;
    for (int i = 0; i < 20; i++) begin
      step;
      if (b_if.m_valid) begin
        if (held == 8'h00) held = b_if.m_data;
        else if (b_if.m_data != held) unstable++;
      end
    end
    check("fl_single_read", rd_b - rbase, 1);
    check("fl_valid_held", b_if.m_valid, 1);
    check("fl_data_held", b_if.m_data, 8'h5A);
    check("fl_stable", unstable, 0);
    base = hs_b;
    b_if.m_ready = 1'b1;
    k = 0;
    while ((hs_b < base + 2 || b_if.busy) && k < 40) begin step; k++; end
    check("fl_delivered", hs_b - base, 2);
    check("fl_pending_clear", dut_b.flush_pending_q, 0);

    // full FIFO on B: usedw reads 0, level must be DEPTH
    rbase = rd_b; base = hs_b;
    for (int i = 0; i < 4; i++) write_b(8'($urandom));
    check("full_no_early_read", rd_b - rbase, 0);
    k = 0;
    while ((hs_b < base + 4 || b_if.busy) && k < 40) begin step; k++; end
    check("full_drained", hs_b - base, 4);
    check("full_empty_after", b_if.fifo_empty, 1);

    // enable drop mid-burst on A
    base = hs_a;
    for (int i = 0; i < 8; i++) write_a(8'($urandom));
    k = 0;
    while (hs_a < base + 3 && k < 60) begin step; k++; end
    a_if.enable = 1'b0;
    repeat (20) step;
    check("en_one_more", hs_a - base, 4);
    check("en_idle", a_if.busy, 0);
    check("en_left", cnt_a, 4);
    a_if.enable = 1'b1;
    k = 0;
    while ((hs_a < base + 8 || a_if.busy) && k < 60) begin step; k++; end
    check("en_resume", hs_a - base, 8);

    // reset while a word sits in HOLD on A
    a_if.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_a(8'($urandom));
    k = 0;
    while (!a_if.m_valid && k < 20) begin step; k++; end
    check("rs_in_hold", a_if.m_valid, 1);
    aclr = 1'b1;
    #1;
    check("rs_m_valid", a_if.m_valid, 0);
    check("rs_rdreq", a_if.fifo_rdreq, 0);
    check("rs_busy", a_if.busy, 0);
    check("rs_tx_count", a_if.tx_count, 0);
    void'(exp_a.pop_front());
    step;
    aclr = 1'b0;
    hs_rst = hs_a;
    a_if.m_ready = 1'b1;
    rbase = rd_a;
    repeat (30) step;
    check("rs_no_read", rd_a - rbase, 0);
    a_if.flush = 1'b1; step; a_if.flush = 1'b0;
    k = 0;
    while ((exp_a.size() != 0 || a_if.busy) && k < 60) begin step; k++; end
    check("rs_drained", exp_a.size(), 0);
    check("rs_tx_after", a_if.tx_count, 16'(hs_a - hs_rst));

    // randomized traffic on A with backpressure and stray flushes
    for (int i = 0; i < 300; i++) begin
      a_if.m_ready = ($urandom_range(0, 3) != 0);
      a_if.flush   = ($urandom_range(0, 19) == 0);
      if (cnt_a < 13 && $urandom_range(0, 1) == 1) begin
        wr_a = 1'b1; wd_a = 8'($urandom); exp_a.push_back(wd_a);
      end else begin
        wr_a = 1'b0;
      end
      step;
    end
    wr_a = 1'b0;
    a_if.flush = 1'b1; a_if.m_ready = 1'b1; step; a_if.flush = 1'b0;
    k = 0;
    while ((exp_a.size() != 0 || a_if.busy || cnt_a != 0) && k < 400) begin step; k++; end
    check("rnd_drained", exp_a.size(), 0);
    check("rnd_tx_count", a_if.tx_count, 16'(hs_a - hs_rst));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
